// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// 8N1 UART receiver: 2-flop synchroniser, start-bit qualification, mid-bit sampling.
// Optional 2-of-3 majority sampling around each bit centre when UART_RX_MAJORITY_EN is defined.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | line idle, waiting for a falling edge on rx_s
// S_START | timing to mid start bit; low confirms the start, high is a glitch
// S_DATA  | sampling L data bits, one per D cycles, LSB first
// S_STOP  | sampling the stop bit; high delivers the word, low flags an error
module uart_rx #(
  parameter int D = 234,
  parameter int L = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_rxd,
  output logic [L-1:0] o_data,
  output logic         o_valid,
  output logic         o_frame_err,
  output logic         o_busy
);

  localparam int CW = $clog2(D);
  localparam int BW = $clog2(L + 1);

`ifdef UART_RX_MAJORITY_EN
  // Decision lands one cycle after the bit centre so the third vote is available.
  localparam logic [CW-1:0] S_DEC = CW'(D / 2);
`else
  localparam logic [CW-1:0] S_DEC = CW'(D / 2 - 1);
`endif
  localparam logic [CW-1:0] B_DEC = CW'(D - 1);
  localparam logic [BW-1:0] LAST  = BW'(L - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t          state, state_n;
  logic            rx_m, rx_s, rx_q;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   tgt;
  logic [BW-1:0]   bit_idx;
  logic [L-1:0]    shreg;
  logic            smp;
  logic            dec;
  logic            cnt_clr, shift_en, idx_clr, load, ferr;

`ifdef UART_RX_MAJORITY_EN
  logic h_a, h_b;
  assign smp = (h_a & h_b) | (h_a & rx_s) | (h_b & rx_s);
`else
  assign smp = rx_s;
`endif

  assign o_busy = (state != S_IDLE);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rx_m        <= 1'b1;
      rx_s        <= 1'b1;
      rx_q        <= 1'b1;
      state       <= S_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      rx_m        <= i_rxd;
      rx_s        <= rx_m;
      rx_q        <= rx_s;
      state       <= state_n;
      cnt         <= cnt_clr ? '0 : cnt + 1'b1;
      o_valid     <= load;
      o_frame_err <= ferr;
      if (idx_clr)
        bit_idx <= '0;
      else if (shift_en)
        bit_idx <= bit_idx + 1'b1;
      if (shift_en)
        shreg <= (shreg >> 1) | (L'(smp) << (L - 1));
      if (load)
        o_data <= shreg;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      h_a <= 1'b1;
      h_b <= 1'b1;
    end else begin
      if (cnt == tgt - CW'(2))
        h_a <= rx_s;
      if (cnt == tgt - CW'(1))
        h_b <= rx_s;
    end
  end
`endif

  always_comb begin
    state_n  = state;
    cnt_clr  = 1'b0;
    shift_en = 1'b0;
    idx_clr  = 1'b0;
    load     = 1'b0;
    ferr     = 1'b0;
    tgt      = (state == S_START) ? S_DEC : B_DEC;
    dec      = (state != S_IDLE) && (cnt == tgt);
    case (state)
      S_IDLE: begin
        cnt_clr = 1'b1;
        if (rx_q && !rx_s)
          state_n = S_START;
      end
      S_START: begin
        if (dec) begin
          cnt_clr = 1'b1;
          idx_clr = 1'b1;
          state_n = smp ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (dec) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_idx == LAST)
            state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (dec) begin
          cnt_clr = 1'b1;
          state_n = S_IDLE;
          if (smp)
            load = 1'b1;
          else
            ferr = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// Scoreboard bench for uart_rx: directed frames push expected events, a monitor pops on each pulse.
module tb_uart_rx;

  localparam int D = 234;
  localparam int L = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         rxd = 1'b1;
  logic [L-1:0] o_data;
  logic         o_valid, o_frame_err, o_busy;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   busy_rise = 0;
  logic busy_d = 1'b0;

  always #5 clk = ~clk;

  uart_rx #(.D(D), .L(L)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_rxd      (rxd),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_frame_err(o_frame_err),
    .o_busy     (o_busy)
  );

  // Monitor: every output pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_valid && o_frame_err) begin
        n_cmp++;
        n_bad++;
        $display("FAIL both_pulses: valid=1 frame_err=1, required never both");
      end else if (o_valid || o_frame_err) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_event: valid=%0b frame_err=%0b data=%02h, required no event",
                   o_valid, o_frame_err, o_data);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (e.is_err != o_frame_err || o_data !== e.data) begin
            n_bad++;
            $display("FAIL event: got err=%0b data=%02h, required err=%0b data=%02h",
                     o_frame_err, o_data, e.is_err, e.data);
          end
        end
      end
    end
    if (o_busy && !busy_d)
      busy_rise++;
    busy_d = o_busy;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push(input bit is_err, input logic [7:0] data);
    exp_t e;
    e.is_err = is_err;
    e.data   = data;
    q.push_back(e);
  endtask

  // Holds v on the line for n rising edges; returns 1 time unit after the last edge.
  task automatic drive(input logic v, input int n);
    rxd = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop, input bit glitch);
    drive(1'b0, D);
    for (int i = 0; i < L; i++) begin
      if (glitch) begin
        drive(b[i], D / 2);
        drive(~b[i], 1);
        drive(b[i], D - D / 2 - 1);
      end else begin
        drive(b[i], D);
      end
    end
    drive(stop, D);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (q.size() != 0 && t < 4 * D) begin
      @(posedge clk);
      t++;
    end
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_timeout: %0d events outstanding, required 0", name, q.size());
      q.delete();
    end
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] msg [14];
    msg = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20,
            8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h0D, 8'h0A};

    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("reset_data", 32'(o_data), 32'h0);
    check("reset_valid", 32'(o_valid), 32'h0);
    check("reset_ferr", 32'(o_frame_err), 32'h0);
    check("reset_busy", 32'(o_busy), 32'h0);
    rst_n = 1'b1;
    drive(1'b1, 10);

    // Single frame 0x48.
    busy_rise = 0;
    push(1'b0, 8'h48);
    send_byte(8'h48, 1'b1, 1'b0);
    drive(1'b1, 20);
    drain("single");
    check("single_busy_low", 32'(o_busy), 32'h0);
    check("single_busy_pulses", 32'(busy_rise), 32'd1);

    // Back-to-back message, zero idle between frames.
    for (int i = 0; i < 14; i++)
      push(1'b0, msg[i]);
    for (int i = 0; i < 14; i++)
      send_byte(msg[i], 1'b1, 1'b0);
    drive(1'b1, 20);
    drain("message");

    // Short low glitch must be rejected at the start-bit check.
    busy_rise = 0;
    drive(1'b0, D / 4);
    drive(1'b1, 2 * D);
    check("glitch_busy_pulses", 32'(busy_rise), 32'd1);
    check("glitch_busy_low", 32'(o_busy), 32'h0);
    push(1'b0, 8'h55);
    send_byte(8'h55, 1'b1, 1'b0);
    drive(1'b1, 20);
    drain("after_glitch");

    // Framing error followed by a held-low line, then recovery.
    push(1'b1, 8'h55);
    send_byte(8'hA5, 1'b0, 1'b0);
    drain("frame_err");
    busy_rise = 0;
    drive(1'b0, 3 * D);
    check("break_busy_pulses", 32'(busy_rise), 32'd0);
    check("break_busy_low", 32'(o_busy), 32'h0);
    check("break_data_kept", 32'(o_data), 32'h55);
    drive(1'b1, D);
    push(1'b0, 8'h3C);
    send_byte(8'h3C, 1'b1, 1'b0);
    drive(1'b1, 20);
    drain("after_break");

    // Reset during bit 4 of 0xFF abandons the frame.
    drive(1'b0, D);
    for (int i = 0; i < 4; i++)
      drive(1'b1, D);
    drive(1'b1, 50);
    rst_n = 1'b0;
    drive(1'b1, 4);
    rst_n = 1'b1;
    check("midreset_data", 32'(o_data), 32'h0);
    check("midreset_busy", 32'(o_busy), 32'h0);
    drive(1'b1, 2 * D);
    check("midreset_no_event", 32'(q.size()), 32'd0);
    push(1'b0, 8'h12);
    send_byte(8'h12, 1'b1, 1'b0);
    drive(1'b1, 20);
    drain("after_reset");

    // One-cycle inversion exactly at each data-bit centre.
`ifdef UART_RX_MAJORITY_EN
    push(1'b0, 8'h0F);
`else
    push(1'b0, 8'hF0);
`endif
    send_byte(8'h0F, 1'b1, 1'b1);
    drive(1'b1, 20);
    drain("centre_glitch");
    check("final_busy", 32'(o_busy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
